priority_arbiter: RTL and testbench

PRIORITY_ARBITER -- requirements
Module: priority_arbiter

---
 rtl/priority_arbiter.sv | 129 ++++++++++++
 tb/tb_priority_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/priority_arbiter.sv
// priority_arbiter: four-requester arbiter with selectable fixed-priority or
// round-robin selection. An owner keeps the grant for as long as it holds its
// request. After MAX_HOLD grant cycles, the owner is forced off if another
// requester is waiting. Every release goes through one idle cycle.
//
// Ports
//   clk_i     : clock; all state changes on the rising edge
//   rst_i     : synchronous active-high reset
//   mode_i    : 0 = fixed priority (req_i[3] highest), 1 = round-robin
//   req_i     : request vector; each bit stays high until that requester is served
//   gnt_o     : registered one-hot grant; zero when there is no owner
//   gnt_id_o  : registered index of the owner; zero when gnt_o is zero
//   busy_o    : registered; high while an owner holds the grant
//
// state | meaning
// IDLE  | no owner; selects a winner from req_i at the next edge
// GRANT | owner_q holds the grant; hold counter runs
module priority_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       mode_i,
  input  logic [3:0] req_i,
  output logic [3:0] gnt_o,
  output logic [1:0] gnt_id_o,
  output logic       busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;

  logic [1:0] fix_id;
  logic [1:0] rr_id;
  logic [1:0] rr_cand;
  logic [1:0] win_id;
  logic       release_now;

  // Winner selection. Both searches let later matches overwrite earlier ones.
  // For fixed priority, the scan runs upward, so the highest set bit wins.
  // For round-robin, the scan runs from the farthest offset back to the nearest,
  // so the first set bit after last_q wins.
  always_comb begin
    fix_id = 2'd0;
    if (req_i[1]) fix_id = 2'd1;
    if (req_i[2]) fix_id = 2'd2;
    if (req_i[3]) fix_id = 2'd3;

    rr_id   = 2'd0;
    rr_cand = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      rr_cand = last_q + 2'(i + 1);
      if (req_i[rr_cand]) rr_id = rr_cand;
    end

    win_id = mode_i ? rr_id : fix_id;
  end

  // A voluntary release and a forced release lead to the same single move to IDLE.
  assign release_now = !req_i[owner_q] ||
                       ((hold_q == HOLD_LAST) && ((req_i & ~gnt_q) != 4'b0000));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;

    case (state_q)
      IDLE: begin
        if (req_i != 4'b0000) begin
          state_d = GRANT;
          owner_d = win_id;
          last_d  = win_id;
          hold_d  = 4'd0;
          gnt_d   = 4'b0001 << win_id;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_d = IDLE;
          owner_d = 2'd0;
          hold_d  = 4'd0;
          gnt_d   = 4'b0000;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = 2'd0;
        hold_d  = 4'd0;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      hold_q  <= 4'd0;
      gnt_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o    = gnt_q;
  assign gnt_id_o = owner_q;
  assign busy_o   = (state_q == GRANT);

endmodule

// File: tb/tb_priority_arbiter.sv
// Scoreboard bench for priority_arbiter. Each stimulus step pushes the
// hand-computed grant expected after the next edge. A separate monitor pops
// one entry per falling edge and checks gnt, gnt_id and busy.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  logic [3:0] exp_q[$];
  string      tag_q[$];

  priority_arbiter #(.MAX_HOLD(8)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .mode_i   (mode),
    .req_i    (req),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] id_of(input logic [3:0] g);
    case (g)
      4'b0010: id_of = 2'd1;
      4'b0100: id_of = 2'd2;
      4'b1000: id_of = 2'd3;
      default: id_of = 2'd0;
    endcase
  endfunction

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      string      t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      tests_run++;
      if (gnt !== e) begin
        tests_failed++;
        $display("FAIL %s gnt: got %b want %b", t, gnt, e);
      end
      tests_run++;
      if (gnt_id !== id_of(e)) begin
        tests_failed++;
        $display("FAIL %s gnt_id: got %0d want %0d", t, gnt_id, id_of(e));
      end
      tests_run++;
      if (busy !== (e != 4'b0000)) begin
        tests_failed++;
        $display("FAIL %s busy: got %b want %b", t, busy, (e != 4'b0000));
      end
    end
  end

  // Apply inputs for one edge and record the outputs expected after it.
  task automatic cyc(input string t, input logic r, input logic m,
                     input logic [3:0] rq, input logic [3:0] eg);
    rst  = r;
    mode = m;
    req  = rq;
    exp_q.push_back(eg);
    tag_q.push_back(t);
    @(negedge clk);
    #1;
  endtask

  logic [3:0] pe_tab [16];

  initial begin
    pe_tab = '{4'b0000, 4'b0001, 4'b0010, 4'b0010,
               4'b0100, 4'b0100, 4'b0100, 4'b0100,
               4'b1000, 4'b1000, 4'b1000, 4'b1000,
               4'b1000, 4'b1000, 4'b1000, 4'b1000};
    rst  = 1'b1;
    mode = 1'b0;
    req  = 4'b0000;
    @(negedge clk);
    #1;

    cyc("reset", 1, 0, 4'b0000, 4'b0000);
    cyc("reset", 1, 0, 4'b1111, 4'b0000);
    cyc("idle_noreq", 0, 0, 4'b0000, 4'b0000);

    // Fixed priority, all requesting: 8-cycle hold, forced release, one idle cycle, regrant.
    for (int i = 0; i < 8; i++) cyc("fix_hold", 0, 0, 4'b1111, 4'b1000);
    cyc("fix_forced_idle", 0, 0, 4'b1111, 4'b0000);
    cyc("fix_regrant", 0, 0, 4'b1111, 4'b1000);
    cyc("fix_regrant", 0, 0, 4'b1111, 4'b1000);
    cyc("rst_mid_grant", 1, 0, 4'b1111, 4'b0000);

    // Round-robin rotation 0,1,2,3,0, starting from last_owner = 3 after reset.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 8; i++) cyc("rr_rotate", 0, 1, 4'b1111, 4'b0001 << (k % 4));
      cyc("rr_gap", 0, 1, 4'b1111, 4'b0000);
    end
    cyc("reset", 1, 0, 4'b0000, 4'b0000);

    // Voluntary release after 3 grant cycles.
    for (int i = 0; i < 3; i++) cyc("fix_0101", 0, 0, 4'b0101, 4'b0100);
    cyc("vol_release", 0, 0, 4'b0001, 4'b0000);
    cyc("next_owner", 0, 0, 4'b0001, 4'b0001);
    cyc("release_all", 0, 0, 4'b0000, 4'b0000);

    // A single requester is never forced off.
    for (int i = 0; i < 20; i++) cyc("single_hold", 0, 0, 4'b0010, 4'b0010);
    cyc("single_release", 0, 0, 4'b0000, 4'b0000);

    // Reset mid-grant, with a mode change and a non-owner request drop during the grant.
    cyc("reset", 1, 0, 4'b0000, 4'b0000);
    cyc("fix_0110", 0, 0, 4'b0110, 4'b0100);
    cyc("mode_chg_grant", 0, 1, 4'b0110, 4'b0100);
    cyc("nonowner_drop", 0, 1, 4'b0100, 4'b0100);
    cyc("rst_abort", 1, 1, 4'b0110, 4'b0000);
    cyc("rr_after_rst", 0, 1, 4'b0110, 4'b0010);
    cyc("rr_after_rst", 0, 1, 4'b0110, 4'b0010);
    cyc("release_all", 0, 1, 4'b0000, 4'b0000);

    // Forced and voluntary release on the same edge: owner drops at hold = 7 while others wait.
    cyc("reset", 1, 0, 4'b0000, 4'b0000);
    for (int i = 0; i < 8; i++) cyc("both_hold", 0, 0, 4'b1001, 4'b1000);
    cyc("both_release", 0, 0, 4'b0001, 4'b0000);
    cyc("both_next", 0, 0, 4'b0001, 4'b0001);
    cyc("release_all", 0, 0, 4'b0000, 4'b0000);

    // Fixed-priority encoder sweep from IDLE.
    for (int v = 0; v < 16; v++) begin
      cyc("pe_sweep", 0, 0, 4'(v), pe_tab[v]);
      cyc("pe_release", 0, 0, 4'b0000, 4'b0000);
    end

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
